pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
// PURPOSE
//  Generic parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces fixed per-stage registers with one valid/ready stage that adds stall
//  (backpressure), flush (bubble insertion) and an optional 2-entry skid buffer.
//  Control and data fields are held separately. Control is forced to a NOP value
//  whenever the stage holds no valid instruction.
// PARAMETERS
//  CTRL_W     9      width of packed control bundle (RegWrite, ResultSrc, MemWrite, ...)
//  DATA_W     165    width of packed datapath bundle (rs1, rs2, PC, imm, PC+4, Rd)
//  CTRL_NOP   '0     control value driven when out_valid=0 and loaded on reset/flush
//  SKID_EN    1      1: 2-entry skid, in_ready registered; 0: 1 entry, in_ready combinational
//  CLR_DATA   0      1: data fields also zeroed on reset/flush; 0: data retained (power saving)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       upstream stage presents an instruction
//  in_ready   out  1       this stage can accept this cycle
//  in_ctrl    in   CTRL_W  control bundle from upstream
//  in_data    in   DATA_W  data bundle from upstream
//  out_valid  out  1       stage output holds a valid instruction
//  out_ready  in   1       downstream accepts (0 = stall from hazard unit)
//  out_ctrl   out  CTRL_W  control to next stage (CTRL_NOP when !out_valid)
//  out_data   out  DATA_W  data to next stage
//  flush      in   1       kill all held and incoming instructions (branch/jump redirect)
//  occupancy  out  2       number of valid entries held (0..2; max 1 when SKID_EN=0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all valids 0, out_valid=0, out_ctrl=CTRL_NOP, occupancy=0.
//    Data regs are 0 if CLR_DATA=1, otherwise don't-care. in_ready is 1 once rst_n=1.
//  - Handshakes: accept = in_valid & in_ready; issue = out_valid & out_ready.
//    Both sampled at posedge. Upstream holds in_* stable while in_valid & !in_ready.
//  - Latency: 1 cycle. Data accepted at edge N appears on out_* after edge N.
//  - SKID_EN=1: main entry (drives out_*) plus skid entry. in_ready = !skid_valid (pure flop).
//    * accept & main empty or issuing -> load main.
//    * accept & main full & !out_ready -> load skid.
//    * issue & skid_valid -> skid moves to main, skid empties. No new load to skid.
//    * Order is preserved. No drop and no duplication. Full throughput at out_ready=1.
//  - SKID_EN=0: single entry, in_ready = !out_valid | out_ready.
//    Simultaneous issue & accept reloads the entry in the same edge.
//  - Stall: out_ready=0 holds out_ctrl/out_data bit-stable while out_valid=1.
//  - flush=1 (synchronous, highest priority): all valids cleared and ctrl regs set to CTRL_NOP.
//    An accept in the same cycle is discarded. The issue in that cycle still counts for
//    downstream, because flush only affects this stage's next state. out_valid=0 on the
//    next cycle. Flush while empty has no effect.
//  - out_ctrl = out_valid ? main_ctrl : CTRL_NOP. This gating is combinational, so
//    RegWrite/MemWrite can never fire from a bubble.
//  - occupancy = main_valid + skid_valid, updated each edge. Value 2 is reached only
//    when SKID_EN=1 and out_ready=0.
//  - Assertions: skid_valid -> main_valid; in_valid stable while !in_ready (bench-side).
// STRUCTURE
//  - pipe_pkg: typedef struct packed de_ctrl_t/de_data_t (and the other stage bundles),
//    localparams for CTRL_W/DATA_W per stage, and the NOP control constants.
//    Instances pass $bits(...) and the constants.
//  - Sub-module pipe_entry: one slot = valid flop + ctrl reg + data reg, with load/clr
//    inputs and CTRL_NOP/CLR_DATA params. It is instantiated once, or twice when
//    SKID_EN=1 (via generate).
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with occupancy=2 -> out_valid=0, out_ctrl=0,
//    occupancy=0 immediately. in_ready=1 on the first edge after release.
//  2 Streaming: 8 back-to-back ops (data=1..8), out_ready=1 -> outputs 1..8 on
//    consecutive cycles, 1-cycle latency, in_ready stays 1.
//  3 Stall: out_ready=0 for 3 cycles with in_valid=1 (SKID_EN=1) -> occupancy 1->2,
//    in_ready=0, output held. Release -> no loss, order kept.
//  4 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0,
//    out_ctrl=CTRL_NOP, occupancy=0, and the incoming op never appears.
//  5 Bubble gating: CTRL_NOP='0, in_ctrl=9'h1FF with in_valid=0 -> out_ctrl stays 0
//    for all cycles.
//  6 SKID_EN=0 variant: issue and accept in the same cycle with out_ready=1 ->
//    in_ready=1 combinationally, throughput of 1 per cycle.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline bundle types, per-stage widths and NOP control constants.
// Stage buffers are sized from these bundles with $bits.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_ctrl;
    } de_ctrl_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } de_data_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } em_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } em_data_t;

    localparam int DE_CTRL_W = $bits(de_ctrl_t);
    localparam int DE_DATA_W = $bits(de_data_t);
    localparam int EM_CTRL_W = $bits(em_ctrl_t);
    localparam int EM_DATA_W = $bits(em_data_t);

    localparam de_ctrl_t DE_CTRL_NOP = '0;
    localparam em_ctrl_t EM_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// One pipeline slot: valid flag, control register and data register.
// Clear beats load beats kill; control returns to the NOP value on clear.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = DE_CTRL_W,
    parameter int                DATA_W   = DE_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter bit                CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_kill,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_NOP;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end else if (i_kill) begin
            r_valid <= 1'b0;
        end
    end

    // Without clearing, the wide data register needs no reset and only toggles on load.
    generate
        if (CLR_DATA) begin : g_data_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                end else if (i_clr) begin
                    r_data <= '0;
                end else if (i_load) begin
                    r_data <= i_data;
                end
            end
        end else begin : g_data_keep
            always_ff @(posedge clk) begin
                if (i_load && !i_clr) begin
                    r_data <= i_data;
                end
            end
        end
    endgenerate

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready inter-stage pipeline register with stall, flush and an optional
// skid entry; control is forced to CTRL_NOP whenever no instruction is held.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = DE_CTRL_W,
    parameter int                DATA_W   = DE_DATA_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter bit                SKID_EN  = 1'b1,
    parameter bit                CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic              w_accept;
    logic              w_issue;
    logic              w_main_valid;
    logic              w_main_load;
    logic              w_main_kill;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data;
    logic [DATA_W-1:0] w_main_data_d;

    assign w_accept = in_valid & in_ready;
    assign w_issue  = w_main_valid & out_ready;

    pipe_entry #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (flush),
        .i_load  (w_main_load),
        .i_kill  (w_main_kill),
        .i_ctrl  (w_main_ctrl_d),
        .i_data  (w_main_data_d),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic              w_skid_load;
            logic              w_skid_kill;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;

            // Skid only catches an accept that main cannot take; it drains into main on issue.
            assign w_skid_load   = w_accept & w_main_valid & ~w_issue;
            assign w_skid_kill   = w_issue & w_skid_valid;
            assign w_main_load   = (w_issue & w_skid_valid) |
                                   (w_accept & (~w_main_valid | w_issue));
            assign w_main_kill   = w_issue;
            assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : in_ctrl;
            assign w_main_data_d = w_skid_valid ? w_skid_data : in_data;
            assign in_ready      = ~w_skid_valid;

            pipe_entry #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CTRL_NOP (CTRL_NOP),
                .CLR_DATA (CLR_DATA)
            ) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_clr   (flush),
                .i_load  (w_skid_load),
                .i_kill  (w_skid_kill),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );
        end else begin : g_single
            assign w_skid_valid  = 1'b0;
            assign w_main_load   = w_accept;
            assign w_main_kill   = w_issue;
            assign w_main_ctrl_d = in_ctrl;
            assign w_main_data_d = in_data;
            assign in_ready      = ~w_main_valid | out_ready;
        end
    endgenerate

    // Bubbles must never carry live RegWrite/MemWrite downstream.
    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_valid ? w_main_ctrl : CTRL_NOP;
    assign out_data  = w_main_data;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

    a_skid_implies_main: assert property (
        @(posedge clk) disable iff (!rst_n) w_skid_valid |-> w_main_valid
    );

endmodule
